// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and baud-rate helper.
// The state codes are common to the receiver and the reworked UART_Tx.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int C_PAR_NONE = 0;
    localparam int C_PAR_EVEN = 1;

    function automatic int clks_per_bit(input int frq, input int rate);
        return frq / rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// P_RST_VAL sets the value both flops take in reset (1 for idle-high lines).
module sync_2ff #(
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q <= {2{P_RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/even-parity/stop framing, one-cycle
// valid or error strobe at the centre of the last stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int C_CLK_FRQ         = 100000000,
    parameter int C_UART_RATE       = 1000000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_UART_PARITY     = 0,
    parameter int C_UART_STOP       = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         rx,
    output logic [C_UART_DATA_WIDTH-1:0] data,
    output logic                         valid,
    output logic                         busy,
    output logic                         error
);

    localparam int CLKS_PER_BIT = clks_per_bit(C_CLK_FRQ, C_UART_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int W            = C_UART_DATA_WIDTH;
    localparam int BW           = $clog2(W);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic          STP_LAST = (C_UART_STOP == 2);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
        if (W < 5 || W > 9) begin : g_bad_width
            $error("uart_rx: C_UART_DATA_WIDTH must be 5..9");
        end
        if (C_UART_STOP != 1 && C_UART_STOP != 2) begin : g_bad_stop
            $error("uart_rx: C_UART_STOP must be 1 or 2");
        end
    endgenerate

    logic          rx_s;
    logic          rx_d_q;
    logic          fall;
    logic          tick;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic          stp_q,   stp_d;
    logic [W-1:0]  sh_q,    sh_d;
    logic          perr_q,  perr_d;
    logic          ferr_q,  ferr_d;
    logic [W-1:0]  data_q,  data_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    sync_2ff #(.P_RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rstb (rstb),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    assign fall = rx_d_q & ~rx_s;
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stp_d   = stp_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                    bit_d   = '0;
                    stp_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    // A start bit that is high again at its centre was a glitch.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_BIT;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d = CNT_BIT;
                    sh_d  = {rx_s, sh_q[W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = (C_UART_PARITY == C_PAR_EVEN) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    cnt_d   = CNT_BIT;
                    perr_d  = (^sh_q) ^ rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d = CNT_BIT;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
                    if (stp_q == STP_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (perr_q || ferr_q || !rx_s) begin
                            error_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = sh_q;
                        end
                    end else begin
                        stp_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stp_q   <= 1'b0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            rx_d_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stp_q   <= stp_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
            rx_d_q  <= rx_s;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign error = error_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8E2 receiver on separate lines,
// driven by a real-time serial transmitter model with an expected-word queue.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int    CLK_FRQ = 16000000;
    localparam int    RATE    = 1000000;
    localparam real   HALF_NS = 31.25;
    localparam real   BIT_NS  = 1000.0;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       rx_a = 1'b1, rx_p = 1'b1;
    logic [7:0] data_a, data_p;
    logic       valid_a, busy_a, error_a;
    logic       valid_p, busy_p, error_p;

    uart_rx #(.C_CLK_FRQ(CLK_FRQ), .C_UART_RATE(RATE), .C_UART_DATA_WIDTH(8),
              .C_UART_PARITY(0), .C_UART_STOP(1)) u_dut_a (
        .clk(clk), .rstb(rstb), .rx(rx_a),
        .data(data_a), .valid(valid_a), .busy(busy_a), .error(error_a));

    uart_rx #(.C_CLK_FRQ(CLK_FRQ), .C_UART_RATE(RATE), .C_UART_DATA_WIDTH(8),
              .C_UART_PARITY(1), .C_UART_STOP(2)) u_dut_p (
        .clk(clk), .rstb(rstb), .rx(rx_p),
        .data(data_p), .valid(valid_p), .busy(busy_p), .error(error_p));

    always #(HALF_NS) clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;

    exp_t       q_a[$], q_p[$];
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0;
    int         vcyc_a = 0;
    int         ev_a = 0, ev_p = 0, nexp_a = 0, nexp_p = 0;
    logic [7:0] last_a = 8'h00, last_p = 8'h00;
    bit         pv_a, pe_a, pv_p, pe_p;
    bit         bsaw_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input bit p, input logic v, input logic e, input logic [7:0] d,
                       input logic b, input bit pv, input bit pe);
        exp_t x;
        if (!(v || e)) return;
        chk(p ? "p_excl" : "a_excl", {31'd0, v & e}, 0);
        chk(p ? "p_pulse" : "a_pulse", {31'd0, pv | pe}, 0);
        chk(p ? "p_busy_end" : "a_busy_end", {31'd0, b}, 0);
        if (p) ev_p++; else ev_a++;
        if ((p ? q_p.size() : q_a.size()) == 0) begin
            chk(p ? "p_unexpected" : "a_unexpected", 1, 0);
            return;
        end
        x = p ? q_p.pop_front() : q_a.pop_front();
        chk(p ? "p_kind" : "a_kind", {31'd0, e}, {31'd0, x.err});
        if (v) begin
            chk(p ? "p_data" : "a_data", {24'd0, d}, {24'd0, x.d});
            if (p) last_p = x.d; else last_a = x.d;
        end else begin
            chk(p ? "p_data_hold" : "a_data_hold", {24'd0, d}, {24'd0, p ? last_p : last_a});
        end
    endtask

    always @(negedge clk) begin
        if (rstb) begin
            if (busy_a) bsaw_a = 1'b1;
            if (valid_a) vcyc_a = cyc;
            mon(1'b0, valid_a, error_a, data_a, busy_a, pv_a, pe_a);
            mon(1'b1, valid_p, error_p, data_p, busy_p, pv_p, pe_p);
            pv_a = valid_a; pe_a = error_a; pv_p = valid_p; pe_p = error_p;
        end else begin
            pv_a = 0; pe_a = 0; pv_p = 0; pe_p = 0;
        end
    end

    task automatic drive(input bit p, input logic v);
        if (p) rx_p = v; else rx_a = v;
    endtask

    // Serial transmitter: start, 8 data bits LSB first, parity (p line), stop bits.
    task automatic send(input bit p, input logic [7:0] d, input bit pb,
                        input logic [1:0] st, input real scale);
        real bt;
        bt = BIT_NS * scale;
        drive(p, 1'b0); #(bt);
        for (int i = 0; i < 8; i++) begin
            drive(p, d[i]); #(bt);
        end
        if (p) begin
            drive(p, pb); #(bt);
        end
        drive(p, st[0]); #(bt);
        if (p) begin
            drive(p, st[1]); #(bt);
        end
        drive(p, 1'b1);
    endtask

    // Reference rule: a word is good iff every stop bit is 1 and, with parity,
    // the data bits plus the parity bit hold an even number of ones.
    task automatic frame(input bit p, input logic [7:0] d, input bit pb,
                         input logic [1:0] st, input real scale);
        exp_t x;
        int   ones;
        bit   bad;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (p) bad = (st != 2'b11) || (((ones + int'(pb)) % 2) != 0);
        else   bad = (st[0] != 1'b1);
        x.err = bad;
        x.d   = d;
        if (p) begin q_p.push_back(x); nexp_p++; end
        else   begin q_a.push_back(x); nexp_a++; end
        send(p, d, pb, st, scale);
        if (bad) #(2.0 * BIT_NS);
    endtask

    function automatic bit even_pb(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return bit'(ones % 2);
    endfunction

    function automatic real rscale(input int span);
        return 1.0 + real'(int'($urandom_range(0, 2 * span)) - span) / 1000.0;
    endfunction

    initial begin
        #(10_000_000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         t0, ev0;
        logic [7:0] d;
        repeat (5) @(negedge clk);
        chk("rst_data_a", {24'd0, data_a}, 0);
        chk("rst_valid_a", {31'd0, valid_a}, 0);
        chk("rst_busy_a", {31'd0, busy_a}, 0);
        chk("rst_error_a", {31'd0, error_a}, 0);
        chk("rst_data_p", {24'd0, data_p}, 0);
        chk("rst_busy_p", {31'd0, busy_p}, 0);
        rstb = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5, nominal timing: start fall to valid ~ 2 sync + 9.5 bits.
        t0 = cyc;
        frame(1'b0, 8'hA5, 1'b0, 2'b11, 1.0);
        #(2.0 * BIT_NS);
        chk("a5_latency_ok", {31'd0, (vcyc_a - t0 >= 152) && (vcyc_a - t0 <= 158)}, 1);
        chk("a5_data", {24'd0, data_a}, 32'hA5);

        // Short low glitch: receiver goes busy, then silently back to idle.
        bsaw_a = 1'b0;
        ev0 = ev_a;
        @(negedge clk) rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_seen", {31'd0, bsaw_a}, 1);
        chk("glitch_busy_now", {31'd0, busy_a}, 0);
        chk("glitch_no_event", ev_a, ev0);
        chk("glitch_data", {24'd0, data_a}, 32'hA5);

        // Framing error, then recovery with a good word.
        frame(1'b0, 8'h3C, 1'b0, 2'b00, 1.0);
        frame(1'b0, 8'h11, 1'b0, 2'b11, 1.0);
        #(BIT_NS);
        chk("after_err_data", {24'd0, data_a}, 32'h11);

        // Even parity: 0x07 with parity 1 good, with parity 0 bad.
        frame(1'b1, 8'h07, 1'b1, 2'b11, 1.0);
        frame(1'b1, 8'h07, 1'b0, 2'b11, 1.0);
        #(BIT_NS);
        chk("par_data", {24'd0, data_p}, 32'h07);

        // Back-to-back frames with the transmitter 2% fast and 2% slow.
        frame(1'b0, 8'h00, 1'b0, 2'b11, 0.98);
        frame(1'b0, 8'hFF, 1'b0, 2'b11, 0.98);
        frame(1'b0, 8'h55, 1'b0, 2'b11, 0.98);
        frame(1'b0, 8'h00, 1'b0, 2'b11, 1.02);
        frame(1'b0, 8'hFF, 1'b0, 2'b11, 1.02);
        frame(1'b0, 8'h55, 1'b0, 2'b11, 1.02);
        #(2.0 * BIT_NS);

        // Reset in the middle of data bit 4; bits 4..7 high so the tail is idle-like.
        d = 8'hF0 | 8'($urandom_range(0, 15));
        fork
            send(1'b0, d, 1'b0, 2'b11, 1.0);
            begin
                #(5.3 * BIT_NS);
                @(negedge clk) rstb = 1'b0;
                @(negedge clk);
                chk("mid_rst_data_a", {24'd0, data_a}, 0);
                chk("mid_rst_busy_a", {31'd0, busy_a}, 0);
                chk("mid_rst_valid_a", {31'd0, valid_a}, 0);
                chk("mid_rst_error_a", {31'd0, error_a}, 0);
                chk("mid_rst_data_p", {24'd0, data_p}, 0);
                repeat (2) @(negedge clk);
                rstb = 1'b1;
                last_a = 8'h00;
                last_p = 8'h00;
            end
        join
        #(2.0 * BIT_NS);
        chk("post_rst_busy", {31'd0, busy_a}, 0);
        chk("post_rst_data", {24'd0, data_a}, 0);

        // Random traffic on both receivers concurrently.
        fork
            for (int n = 0; n < 256; n++) begin
                frame(1'b0, 8'($urandom), 1'b0,
                      ($urandom_range(0, 15) == 0) ? 2'b00 : 2'b11, rscale(15));
            end
            for (int n = 0; n < 60; n++) begin
                logic [7:0] dp;
                bit         pb;
                logic [1:0] st;
                dp = 8'($urandom);
                pb = even_pb(dp) ^ ($urandom_range(0, 7) == 0);
                st = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                frame(1'b1, dp, pb, st, rscale(10));
            end
        join
        #(3.0 * BIT_NS);

        chk("a_queue_empty", q_a.size(), 0);
        chk("p_queue_empty", q_p.size(), 0);
        chk("a_event_count", ev_a, nexp_a);
        chk("p_event_count", ev_p, nexp_p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
